shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
- Parametrised, two-stage pipelined barrel shifter for the datapath's operand-2 path. Implements LSL/LSR/ASR/ROR/RRX with full ARM shifter carry-out semantics.
- Accepts register-specified amounts (0..255) and immediate-encoded amounts.
- Valid/ready handshake on both sides, so it can sit between the register-read and execute stages and absorb back-pressure from a stalled execute stage.

Parameters:
- WIDTH, 32, data width; must be a power of two, 8..128.
- AMT_W, 8, shift-amount width; the amount is taken as an unsigned value (register bottom byte).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input op valid
- in_ready  out  1  pipeline can accept an op this cycle
- in_a  in  WIDTH  value to shift
- in_amt  in  AMT_W  shift amount
- in_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- in_imm  in  1  1 = immediate encoding (amount 0 is special), 0 = register encoding
- in_carry  in  1  current C flag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_y  out  WIDTH  shifted result
- out_carry  out  1  shifter carry-out

Behaviour:
- Stages: S1 registers the op and decodes the effective amount and mode. S2 registers the result and carry.
  - Each stage has a valid bit.
  - S2 loads when !s2_valid || out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || s1_advances (combinational; no input-to-input-ready loop through in_valid).
- Latency: exactly 2 cycles from an accepted input to out_valid with no back-pressure. Throughput is 1 op/cycle.
- Stall: while out_valid && !out_ready, out_y and out_carry hold stable. S1 holds if full. in_ready falls when both stages are full.
- Transfer: occurs on valid && ready at either port. No bubbles are inserted when both stages are full and out_ready = 1.
- Reset: s1_valid = s2_valid = 0, out_y = 0, out_carry = 0. In-flight ops are dropped. in_ready = 1 in the first cycle after reset deasserts.
- Arithmetic, with W = WIDTH and n = effective amount:
  - Register encoding, n = 0 (all types): y = a, c = in_carry.
  - LSL, 1..W-1: y = a<<n, c = a[W-n]. n = W: y = 0, c = a[0]. n > W: y = 0, c = 0.
  - LSR, 1..W-1: y = a>>n, c = a[n-1]. n = W: y = 0, c = a[W-1]. n > W: y = 0, c = 0.
  - ASR, 1..W-1: arithmetic shift, c = a[n-1]. n >= W: y = all a[W-1], c = a[W-1].
  - ROR, n%W != 0: rotate by n%W, c = y[W-1]. n != 0 with n%W = 0: y = a, c = a[W-1].
  - Immediate encoding (in_imm = 1), amount field 0:
    - LSL: y = a, c = in_carry.
    - LSR/ASR: treated as n = W.
    - ROR: RRX, y = {in_carry, a[W-1:1]}, c = a[0].
  - Immediate encoding, nonzero amount: identical to register encoding.
- No state beyond the pipeline registers. Inputs sampled only on accept.

Optional Feature:
- Macro SHIFT_PIPE_CARRY_EN.
- Defined: out_carry is computed per the rules above and pipelined with out_y.
- Undefined: carry logic is omitted. out_carry is the registered in_carry of the same op (pass-through, same latency). out_y is unchanged.

Decomposition:
- Shared package shift_pkg holds:
  - shift-type constants SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11;
  - the S1-to-S2 decoded-op struct/typedef (a, n, type, rrx flag, zero flag, carry).
- One sub-module, shift_core: purely combinational WIDTH-parametrised shift + carry from the decoded op. It is instantiated in S2 so it can be unit-tested standalone.

Test Plan:
- LSL, a = 0x80000001, amt = 1, reg -> after 2 cycles y = 0x00000002, c = 1. Same with amt = 32 -> y = 0, c = 1. Same with amt = 33 -> y = 0, c = 0.
- ASR, a = 0x80000000, amt = 40 -> y = 0xFFFFFFFF, c = 1. Same a, LSR imm with amt = 0 -> y = 0, c = 1.
- ROR reg, a = 0x0000000F, amt = 4 -> y = 0xF0000000, c = 1. Same a, amt = 64 -> y = 0x0000000F, c = 0. Same a, ROR imm with amt = 0, in_carry = 1 -> RRX y = 0x80000007, c = 1.
- Back-to-back stream: 4 ops on consecutive cycles, out_ready = 1 -> 4 results on consecutive cycles in order.
- Back-pressure: hold out_ready = 0 for 3 cycles with 3 ops offered -> in_ready drops after 2 accepts; out_y stays stable; nothing is lost or duplicated on release.
- Reset asserted while both stages are full -> next cycle out_valid = 0, out_y = 0, in_ready = 1. The subsequent op completes with 2-cycle latency.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the shift_pipe operand-2 shifter: shift-type codes and the
// decoded op carried from S1 into S2.
package shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Sized for the widest supported datapath; narrower instances zero-extend a.
    localparam int SHIFT_MAX_W = 128;
    // Wide enough to hold WIDTH+1, the "beyond width" marker for LSL/LSR.
    localparam int SHIFT_N_W   = 9;

    typedef struct packed {
        logic [SHIFT_MAX_W-1:0] a;
        logic [SHIFT_N_W-1:0]   n;
        logic [1:0]             sh_type;
        logic                   rrx;
        logic                   zero;
        logic                   carry;
    } shift_op_t;

endpackage

// File: rtl/shift_core.sv
// Combinational WIDTH-bit shifter for one decoded op.
// SHIFT_PIPE_CARRY_EN compiles in the ARM carry-out; otherwise carry echoes op.carry.
module shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  shift_op_t        op,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    localparam logic [SHIFT_N_W-1:0] W_N = SHIFT_N_W'(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] ror_y;

    assign a     = op.a[WIDTH-1:0];
    assign ror_y = (a >> op.n) | (a << (W_N - op.n));

    generate
        if (WIDTH < SHIFT_MAX_W) begin : g_hi
            logic unused_a_hi;
            assign unused_a_hi = ^op.a[SHIFT_MAX_W-1:WIDTH];
        end
    endgenerate

    // Shifts by >= WIDTH naturally yield 0 (or all-sign for ASR).
    always_comb begin
        y = a;
        if (op.zero) begin
            y = a;
        end else if (op.rrx) begin
            y = {op.carry, a[WIDTH-1:1]};
        end else begin
            case (op.sh_type)
                SH_LSL:  y = a << op.n;
                SH_LSR:  y = a >> op.n;
                SH_ASR:  y = $unsigned($signed(a) >>> op.n);
                default: y = ror_y;
            endcase
        end
    end

`ifdef SHIFT_PIPE_CARRY_EN
    logic [SHIFT_N_W-1:0] n_m1;
    logic [WIDTH-1:0]     lsl_pre;
    logic [WIDTH-1:0]     lsr_pre;

    // Shifting by n-1 leaves the last bit shifted out at the edge.
    assign n_m1    = op.n - SHIFT_N_W'(1);
    assign lsl_pre = a << n_m1;
    assign lsr_pre = a >> n_m1;

    always_comb begin
        carry = op.carry;
        if (op.zero) begin
            carry = op.carry;
        end else if (op.rrx) begin
            carry = a[0];
        end else begin
            case (op.sh_type)
                SH_LSL:  carry = (op.n <= W_N) ? lsl_pre[WIDTH-1] : 1'b0;
                SH_LSR:  carry = (op.n <= W_N) ? lsr_pre[0] : 1'b0;
                SH_ASR:  carry = (op.n < W_N) ? lsr_pre[0] : a[WIDTH-1];
                default: carry = ror_y[WIDTH-1];
            endcase
        end
    end
`else
    assign carry = op.carry;
`endif

endmodule

// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR/RRX) with valid/ready on both ports.
// SHIFT_PIPE_CARRY_EN selects the ARM carry-out; otherwise out_carry is the op's in_carry.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_type,
    input  logic             in_imm,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_carry
);

    localparam int CMP_W = ((AMT_W > SHIFT_N_W) ? AMT_W : SHIFT_N_W) + 1;
    localparam int LOG_W = $clog2(WIDTH);

    shift_op_t        s1_op;
    shift_op_t        s1_next;
    logic             s1_valid;
    logic             s2_valid;
    logic             s2_load;
    logic             s1_adv;
    logic             in_fire;
    logic             amt_zero;
    logic [WIDTH-1:0] core_y;
    logic             core_carry;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_load;
    assign in_ready  = !s1_valid || s1_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign amt_zero  = (in_amt == '0);

    // Reduce the amount to what the shifter needs: ROR only cares about n mod WIDTH,
    // LSL/LSR/ASR collapse every amount beyond WIDTH onto WIDTH+1.
    always_comb begin
        s1_next         = '0;
        s1_next.a       = SHIFT_MAX_W'(in_a);
        s1_next.sh_type = in_type;
        s1_next.carry   = in_carry;
        s1_next.zero    = amt_zero && (!in_imm || in_type == SH_LSL);
        s1_next.rrx     = amt_zero && in_imm && in_type == SH_ROR;
        if (in_type == SH_ROR) begin
            s1_next.n = SHIFT_N_W'(in_amt[LOG_W-1:0]);
        end else if (amt_zero && in_imm) begin
            s1_next.n = SHIFT_N_W'(WIDTH);
        end else if (CMP_W'(in_amt) > CMP_W'(WIDTH)) begin
            s1_next.n = SHIFT_N_W'(WIDTH + 1);
        end else begin
            s1_next.n = SHIFT_N_W'(in_amt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_op <= s1_next;
            end
        end
    end

    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op    (s1_op),
        .y     (core_y),
        .carry (core_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            out_y     <= '0;
            out_carry <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_y     <= core_y;
                out_carry <= core_carry;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, streaming, back-pressure,
// mid-flight reset and a randomized run against a bit-serial reference model.
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [7:0]  in_amt;
    logic [1:0]  in_type;
    logic        in_imm;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_carry;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] y;
        logic        c;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  amt;
        logic [1:0]  t;
        logic        imm;
        logic        cin;
        logic [31:0] y;
        logic        c;
    } vec_t;

    localparam int NVEC = 14;
    localparam vec_t VECS [NVEC] = '{
        '{32'h80000001,  8'd1, 2'd0, 1'b0, 1'b0, 32'h00000002, 1'b1},
        '{32'h80000001, 8'd32, 2'd0, 1'b0, 1'b0, 32'h00000000, 1'b1},
        '{32'h80000001, 8'd33, 2'd0, 1'b0, 1'b1, 32'h00000000, 1'b0},
        '{32'h80000000, 8'd40, 2'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1},
        '{32'h80000000,  8'd0, 2'd1, 1'b1, 1'b0, 32'h00000000, 1'b1},
        '{32'h0000000F,  8'd4, 2'd3, 1'b0, 1'b0, 32'hF0000000, 1'b1},
        '{32'h0000000F, 8'd64, 2'd3, 1'b0, 1'b1, 32'h0000000F, 1'b0},
        '{32'h0000000F,  8'd0, 2'd3, 1'b1, 1'b1, 32'h80000007, 1'b1},
        '{32'h00001234,  8'd0, 2'd1, 1'b0, 1'b1, 32'h00001234, 1'b1},
        '{32'h00001234,  8'd0, 2'd0, 1'b1, 1'b0, 32'h00001234, 1'b0},
        '{32'h40000000,  8'd0, 2'd2, 1'b1, 1'b1, 32'h00000000, 1'b0},
        '{32'h000000F0,  8'd5, 2'd1, 1'b0, 1'b0, 32'h00000007, 1'b1},
        '{32'hF0000000,  8'd4, 2'd2, 1'b0, 1'b0, 32'hFF000000, 1'b0},
        '{32'h00000001, 8'd31, 2'd0, 1'b0, 1'b0, 32'h80000000, 1'b0}
    };

    res_t exp_q[$];

    shift_pipe #(
        .WIDTH (32),
        .AMT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_type   (in_type),
        .in_imm    (in_imm),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    // Reference: apply the shift one bit position at a time; carry is the last bit moved out.
    function automatic res_t ref_shift(logic [31:0] a, logic [7:0] amt, logic [1:0] t,
                                       logic imm, logic cin);
        res_t        r;
        logic [31:0] y;
        logic        c;
        int          n;
        y = a;
        c = cin;
        n = int'(amt);
        if (amt == 8'd0) begin
            n = 0;
            if (imm && t == 2'd3) begin
                y = {cin, a[31:1]};
                c = a[0];
            end else if (imm && (t == 2'd1 || t == 2'd2)) begin
                n = 32;
            end
        end
        for (int i = 0; i < n; i++) begin
            case (t)
                2'd0: begin c = y[31]; y = {y[30:0], 1'b0}; end
                2'd1: begin c = y[0];  y = {1'b0, y[31:1]}; end
                2'd2: begin c = y[0];  y = {y[31], y[31:1]}; end
                default: begin c = y[0]; y = {y[0], y[31:1]}; end
            endcase
        end
        r.y = y;
`ifdef SHIFT_PIPE_CARRY_EN
        r.c = c;
`else
        r.c = cin;
`endif
        return r;
    endfunction

    task automatic drive_random_op();
        in_a     = $urandom;
        case ($urandom_range(0, 3))
            0: in_amt = 8'($urandom_range(0, 255));
            1: in_amt = 8'($urandom_range(0, 40));
            2: in_amt = 8'(32 * $urandom_range(0, 3));
            default: in_amt = 8'($urandom_range(0, 2));
        endcase
        in_type  = 2'($urandom_range(0, 3));
        in_imm   = 1'($urandom_range(0, 1));
        in_carry = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_amt    = '0;
        in_type   = '0;
        in_imm    = 1'b0;
        in_carry  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_y !== 32'h0 || out_carry !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_state got v=%b y=%h c=%b rdy=%b exp v=0 y=0 c=0 rdy=1",
                     out_valid, out_y, out_carry, in_ready);
    endtask

    task automatic test_directed();
        logic exp_c;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_a      = VECS[i].a;
            in_amt    = VECS[i].amt;
            in_type   = VECS[i].t;
            in_imm    = VECS[i].imm;
            in_carry  = VECS[i].cin;
            out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL directed_ready[%0d] got=%b exp=1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL directed_early[%0d] out_valid got=%b exp=0", i, out_valid);
            end
            @(negedge clk);
`ifdef SHIFT_PIPE_CARRY_EN
            exp_c = VECS[i].c;
`else
            exp_c = VECS[i].cin;
`endif
            checks++;
            if (out_valid !== 1'b1 || out_y !== VECS[i].y || out_carry !== exp_c) begin
                failures++;
                $display("FAIL directed[%0d] got v=%b y=%h c=%b exp v=1 y=%h c=%b",
                         i, out_valid, out_y, out_carry, VECS[i].y, exp_c);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 4);
            drive_random_op();
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready cyc=%0d got=%b exp=1", cyc, in_ready);
            end
            checks++;
            if (out_valid !== (cyc >= 2 && cyc < 6)) begin
                failures++;
                $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc >= 2 && cyc < 6));
            end
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_y !== e.y || out_carry !== e.c) begin
                    failures++;
                    $display("FAIL b2b_data cyc=%0d got y=%h c=%b exp y=%h c=%b",
                             cyc, out_y, out_carry, e.y, e.c);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_shift(in_a, in_amt, in_type, in_imm, in_carry));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] ops_a   [3];
        logic [7:0]  ops_amt [3];
        logic [1:0]  ops_t   [3];
        logic        ops_imm [3];
        logic        ops_cin [3];
        res_t        e;
        int          idx;
        int          got;
        logic [31:0] held_y;
        logic        held_c;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            drive_random_op();
            ops_a[k] = in_a; ops_amt[k] = in_amt; ops_t[k] = in_type;
            ops_imm[k] = in_imm; ops_cin[k] = in_carry;
        end
        idx    = 0;
        got    = 0;
        held_y = '0;
        held_c = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a = ops_a[idx]; in_amt = ops_amt[idx]; in_type = ops_t[idx];
            in_imm = ops_imm[idx]; in_carry = ops_cin[idx];
            #1;
            checks++;
            if (in_ready !== (cyc < 2)) begin
                failures++;
                $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (cyc < 2));
            end
            if (cyc == 2) begin
                held_y = out_y;
                held_c = out_carry;
                checks++;
                if (out_valid !== 1'b1 || out_y !== exp_q[0].y || out_carry !== exp_q[0].c) begin
                    failures++;
                    $display("FAIL bp_head got v=%b y=%h c=%b exp v=1 y=%h c=%b",
                             out_valid, out_y, out_carry, exp_q[0].y, exp_q[0].c);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_a, in_amt, in_type, in_imm, in_carry));
                idx++;
            end
        end
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (out_y !== held_y || out_carry !== held_c) begin
                    failures++;
                    $display("FAIL bp_stable got y=%h c=%b exp y=%h c=%b", out_y, out_carry, held_y, held_c);
                end
            end
            out_ready = 1'b1;
            in_valid  = (idx < 3);
            if (idx < 3) begin
                in_a = ops_a[idx]; in_amt = ops_amt[idx]; in_type = ops_t[idx];
                in_imm = ops_imm[idx]; in_carry = ops_cin[idx];
            end
            #1;
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra got y=%h exp none", out_y);
                end else begin
                    e = exp_q.pop_front();
                    if (out_y !== e.y || out_carry !== e.c) begin
                        failures++;
                        $display("FAIL bp_data got y=%h c=%b exp y=%h c=%b", out_y, out_carry, e.y, e.c);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_a, in_amt, in_type, in_imm, in_carry));
                idx++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 3) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=3", got);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_dup out_valid got=%b exp=0", out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        res_t e;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_random_op();
        @(negedge clk);
        drive_random_op();
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_full got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_y !== 32'h0 || out_carry !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_flush got v=%b y=%h c=%b rdy=%b exp v=0 y=0 c=0 rdy=1",
                     out_valid, out_y, out_carry, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_random_op();
        e = ref_shift(in_a, in_amt, in_type, in_imm, in_carry);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_after_early got=%b exp=0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_y !== e.y || out_carry !== e.c) begin
            failures++;
            $display("FAIL rst_after got v=%b y=%h c=%b exp v=1 y=%h c=%b",
                     out_valid, out_y, out_carry, e.y, e.c);
        end
    endtask

    task automatic test_random();
        res_t        e;
        logic        hold;
        logic [31:0] hy;
        logic        hc;
        logic        exp_rdy;
        exp_q.delete();
        hold = 1'b0;
        hy   = '0;
        hc   = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_y !== hy || out_carry !== hc) begin
                    failures++;
                    $display("FAIL rnd_hold cyc=%0d got y=%h c=%b exp y=%h c=%b", cyc, out_y, out_carry, hy, hc);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive_random_op();
            #1;
            exp_rdy = (exp_q.size() < 2) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra cyc=%0d got y=%h exp none", cyc, out_y);
                end else begin
                    e = exp_q.pop_front();
                    if (out_y !== e.y || out_carry !== e.c) begin
                        failures++;
                        $display("FAIL rnd_data cyc=%0d got y=%h c=%b exp y=%h c=%b",
                                 cyc, out_y, out_carry, e.y, e.c);
                    end
                end
            end
            hold = out_valid && !out_ready;
            hy   = out_y;
            hc   = out_carry;
            if (in_valid && in_ready)
                exp_q.push_back(ref_shift(in_a, in_amt, in_type, in_imm, in_carry));
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_drain_extra got y=%h exp none", out_y);
                end else begin
                    e = exp_q.pop_front();
                    if (out_y !== e.y || out_carry !== e.c) begin
                        failures++;
                        $display("FAIL rnd_drain got y=%h c=%b exp y=%h c=%b", out_y, out_carry, e.y, e.c);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_lost got_left=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        if (out_valid !== 1'b0 || out_y !== 32'h0 || out_carry !== 1'b0 || in_ready !== 1'b1)
            failures++;
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule
